// File: rtl/simple_processor_pkg.sv
// Shared datapath width and logic-gate function codes for the simple processor.
package simple_processor_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        AND = 2'd0,
        OR  = 2'd1,
        XOR = 2'd2,
        NOT = 2'd3
    } func_t;

endpackage

// File: rtl/gate_operand_fetch.sv
// Operand-fetch/issue stage ahead of alu_gate: register file, scoreboard and hazard stall.
// Define GATE_OPFETCH_BYPASS_EN to forward same-cycle writeback data into the operands.
module gate_operand_fetch
    import simple_processor_pkg::*;
#(
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  func_t                 func_i,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output func_t                 ex_func_o,
    output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
    output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
    output logic [ADDR_WIDTH-1:0] ex_rd_addr_o,
    input  logic                  wb_valid_i,
    input  logic [ADDR_WIDTH-1:0] wb_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic [NUM_REGS-1:0]   pending_o
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_pending;
    logic                  r_ex_valid;
    func_t                 r_ex_func;
    logic [DATA_WIDTH-1:0] r_ex_rs1_data;
    logic [DATA_WIDTH-1:0] r_ex_rs2_data;
    logic [ADDR_WIDTH-1:0] r_ex_rd_addr;

    logic                  w_is_not;
    logic                  w_haz_rs1;
    logic                  w_haz_rs2;
    logic                  w_haz_rd;
    logic                  w_hazard;
    logic                  w_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_rs1_data;
    logic [DATA_WIDTH-1:0] w_rs2_data;
    logic [NUM_REGS-1:0]   w_pending_nxt;

    assign w_is_not = (func_i == NOT);

`ifdef GATE_OPFETCH_BYPASS_EN
    logic w_wb_hit_rs1;
    logic w_wb_hit_rs2;

    // A writeback landing this cycle satisfies the operand directly.
    assign w_wb_hit_rs1 = wb_valid_i && (wb_rd_addr_i == rs1_addr_i);
    assign w_wb_hit_rs2 = wb_valid_i && (wb_rd_addr_i == rs2_addr_i);
    assign w_haz_rs1    = r_pending[rs1_addr_i] && !w_wb_hit_rs1;
    assign w_haz_rs2    = r_pending[rs2_addr_i] && !w_wb_hit_rs2 && !w_is_not;
    assign w_rs1_data   = w_wb_hit_rs1 ? wb_data_i : r_regs[rs1_addr_i];
    assign w_rs2_data   = w_wb_hit_rs2 ? wb_data_i : r_regs[rs2_addr_i];
`else
    assign w_haz_rs1    = r_pending[rs1_addr_i];
    assign w_haz_rs2    = r_pending[rs2_addr_i] && !w_is_not;
    assign w_rs1_data   = r_regs[rs1_addr_i];
    assign w_rs2_data   = r_regs[rs2_addr_i];
`endif

    assign w_haz_rd = r_pending[rd_addr_i];
    assign w_hazard = w_haz_rs1 || w_haz_rs2 || w_haz_rd;
    assign w_ready  = !w_hazard && (!r_ex_valid || ex_ready_i);
    assign w_accept = instr_valid_i && w_ready;

    // Set is applied after clear so an accept wins a same-index collision.
    always_comb begin
        w_pending_nxt = r_pending;
        if (wb_valid_i) begin
            w_pending_nxt[wb_rd_addr_i] = 1'b0;
        end
        if (w_accept) begin
            w_pending_nxt[rd_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_valid_i) begin
            r_regs[wb_rd_addr_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_ex_valid    <= 1'b0;
            r_ex_func     <= AND;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_rd_addr  <= '0;
        end else if (w_accept) begin
            r_ex_valid    <= 1'b1;
            r_ex_func     <= func_i;
            r_ex_rs1_data <= w_rs1_data;
            r_ex_rs2_data <= w_is_not ? '0 : w_rs2_data;
            r_ex_rd_addr  <= rd_addr_i;
        end else if (ex_ready_i) begin
            r_ex_valid    <= 1'b0;
        end
    end

    assign instr_ready_o = w_ready;
    assign ex_valid_o    = r_ex_valid;
    assign ex_func_o     = r_ex_func;
    assign ex_rs1_data_o = r_ex_rs1_data;
    assign ex_rs2_data_o = r_ex_rs2_data;
    assign ex_rd_addr_o  = r_ex_rd_addr;
    assign pending_o     = r_pending;

endmodule

// File: tb/tb_gate_operand_fetch.sv
// Self-checking bench for gate_operand_fetch: scoreboard of issued payloads plus per-scenario checks.
module tb_gate_operand_fetch;
    import simple_processor_pkg::*;

    localparam int NR = 8;
    localparam int AW = 3;
    localparam int DW = DATA_WIDTH;
`ifdef GATE_OPFETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        func_t         func;
        logic [DW-1:0] rs1;
        logic [DW-1:0] rs2;
        logic [AW-1:0] rd;
    } payload_t;

    logic          clk = 1'b0;
    logic          arst_ni = 1'b0;
    logic          instr_valid_i = 1'b0;
    logic          instr_ready_o;
    func_t         func_i = AND;
    logic [AW-1:0] rs1_addr_i = '0;
    logic [AW-1:0] rs2_addr_i = '0;
    logic [AW-1:0] rd_addr_i = '0;
    logic          ex_valid_o;
    logic          ex_ready_i = 1'b1;
    func_t         ex_func_o;
    logic [DW-1:0] ex_rs1_data_o;
    logic [DW-1:0] ex_rs2_data_o;
    logic [AW-1:0] ex_rd_addr_o;
    logic          wb_valid_i = 1'b0;
    logic [AW-1:0] wb_rd_addr_i = '0;
    logic [DW-1:0] wb_data_i = '0;
    logic [NR-1:0] pending_o;

    int checks = 0;
    int errors = 0;

    payload_t      expQ[$];
    payload_t      expP;
    payload_t      gotP;
    logic [DW-1:0] mRegs [NR];
    logic [NR-1:0] mPending = '0;
    logic          mExValid = 1'b0;
    logic          hit1, hit2, mHazard, mReady, mAccept;

    gate_operand_fetch #(.NUM_REGS(NR)) dut (
        .clk_i        (clk),
        .arst_ni      (arst_ni),
        .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o),
        .func_i       (func_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rd_addr_i    (rd_addr_i),
        .ex_valid_o   (ex_valid_o),
        .ex_ready_i   (ex_ready_i),
        .ex_func_o    (ex_func_o),
        .ex_rs1_data_o(ex_rs1_data_o),
        .ex_rs2_data_o(ex_rs2_data_o),
        .ex_rd_addr_o (ex_rd_addr_o),
        .wb_valid_i   (wb_valid_i),
        .wb_rd_addr_i (wb_rd_addr_i),
        .wb_data_i    (wb_data_i),
        .pending_o    (pending_o)
    );

    always #5 clk = ~clk;

    // Reference model and scoreboard, evaluated mid-cycle with inputs stable until the next edge.
    always @(negedge clk) begin
        if (!arst_ni) begin
            for (int i = 0; i < NR; i++) mRegs[i] = '0;
            mPending = '0;
            mExValid = 1'b0;
            expQ.delete();
        end else begin
            checks++;
            if (ex_valid_o !== mExValid) begin
                errors++;
                $display("[TB] FAIL ex_valid got %b want %b at %0t", ex_valid_o, mExValid, $time);
            end
            checks++;
            if (pending_o !== mPending) begin
                errors++;
                $display("[TB] FAIL pending got %b want %b at %0t", pending_o, mPending, $time);
            end
            hit1    = BYPASS && wb_valid_i && (wb_rd_addr_i == rs1_addr_i);
            hit2    = BYPASS && wb_valid_i && (wb_rd_addr_i == rs2_addr_i);
            mHazard = (mPending[rs1_addr_i] && !hit1)
                   || (mPending[rs2_addr_i] && (func_i != NOT) && !hit2)
                   || mPending[rd_addr_i];
            mReady  = !mHazard && (!mExValid || ex_ready_i);
            mAccept = instr_valid_i && mReady;
            checks++;
            if (instr_ready_o !== mReady) begin
                errors++;
                $display("[TB] FAIL instr_ready got %b want %b at %0t", instr_ready_o, mReady, $time);
            end
            if (mExValid && ex_ready_i) begin
                checks++;
                gotP = '{ex_func_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o};
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL payload got %h want <none> at %0t", gotP, $time);
                end else begin
                    expP = expQ.pop_front();
                    if (gotP !== expP) begin
                        errors++;
                        $display("[TB] FAIL payload got %h want %h at %0t", gotP, expP, $time);
                    end
                end
                mExValid = 1'b0;
            end
            if (mAccept) begin
                expP.func = func_i;
                expP.rs1  = hit1 ? wb_data_i : mRegs[rs1_addr_i];
                expP.rs2  = (func_i == NOT) ? '0 : (hit2 ? wb_data_i : mRegs[rs2_addr_i]);
                expP.rd   = rd_addr_i;
                expQ.push_back(expP);
                mExValid = 1'b1;
            end
            if (wb_valid_i) begin
                mRegs[wb_rd_addr_i]    = wb_data_i;
                mPending[wb_rd_addr_i] = 1'b0;
            end
            if (mAccept) mPending[rd_addr_i] = 1'b1;
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input bit v, input func_t f, input logic [AW-1:0] a,
                               input logic [AW-1:0] b, input logic [AW-1:0] d);
        instr_valid_i = v;
        func_i        = f;
        rs1_addr_i    = a;
        rs2_addr_i    = b;
        rd_addr_i     = d;
    endtask

    task automatic drive_wb(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_valid_i   = v;
        wb_rd_addr_i = a;
        wb_data_i    = d;
    endtask

    task automatic test_reset();
        arst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ex_valid_o !== 1'b0 || ex_func_o !== AND || ex_rs1_data_o !== '0 ||
            ex_rs2_data_o !== '0 || ex_rd_addr_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ex got %b/%0d/%h/%h/%0d want 0/0/00/00/0",
                     ex_valid_o, ex_func_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o);
        end
        checks++;
        if (pending_o !== '0 || instr_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_state got pending %b ready %b want 00000000 1", pending_o, instr_ready_o);
        end
        arst_ni = 1'b1;
        nextCycle();
    endtask

    task automatic test_issue_after_reset();
        ex_ready_i = 1'b1;
        drive_instr(1'b1, AND, 3'd1, 3'd2, 3'd3);
        nextCycle();
        drive_instr(1'b0, AND, 3'd0, 3'd0, 3'd0);
        checks++;
        if (ex_valid_o !== 1'b1 || ex_rs1_data_o !== 8'h00 || ex_rs2_data_o !== 8'h00 || pending_o !== 8'b00001000) begin
            errors++;
            $display("[TB] FAIL first_issue got v%b %h %h pend %b want v1 00 00 pend 00001000",
                     ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, pending_o);
        end
        drive_wb(1'b1, 3'd3, 8'h3C);
        nextCycle();
        drive_wb(1'b0, 3'd0, 8'h00);
    endtask

    task automatic test_raw_stall();
        drive_wb(1'b1, 3'd1, 8'h0F);
        nextCycle();
        drive_wb(1'b1, 3'd2, 8'hF0);
        nextCycle();
        drive_wb(1'b0, 3'd0, 8'h00);
        drive_instr(1'b1, OR, 3'd1, 3'd2, 3'd4);
        nextCycle();
        drive_instr(1'b1, XOR, 3'd4, 3'd1, 3'd5);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (instr_ready_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL raw_stall got ready %b want 0", instr_ready_o);
            end
            nextCycle();
        end
        drive_wb(1'b1, 3'd4, 8'hFF);
        @(negedge clk);
        checks++;
        if (instr_ready_o !== BYPASS) begin
            errors++;
            $display("[TB] FAIL raw_wb_cycle got ready %b want %b", instr_ready_o, BYPASS);
        end
        nextCycle();
        drive_wb(1'b0, 3'd0, 8'h00);
        instr_valid_i = !BYPASS;
        @(negedge clk);
        checks++;
        if (instr_ready_o !== !BYPASS) begin
            errors++;
            $display("[TB] FAIL raw_after_wb got ready %b want %b", instr_ready_o, !BYPASS);
        end
        nextCycle();
        instr_valid_i = 1'b0;
        nextCycle();
        drive_wb(1'b1, 3'd5, 8'h5A);
        nextCycle();
        drive_wb(1'b0, 3'd0, 8'h00);
    endtask

    task automatic test_not_operand();
        drive_instr(1'b1, OR, 3'd0, 3'd0, 3'd2);
        nextCycle();
        drive_instr(1'b1, NOT, 3'd1, 3'd2, 3'd6);
        @(negedge clk);
        checks++;
        if (instr_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL not_nostall got ready %b want 1", instr_ready_o);
        end
        nextCycle();
        drive_instr(1'b0, AND, 3'd0, 3'd0, 3'd0);
        @(negedge clk);
        checks++;
        if (ex_func_o !== NOT || ex_rs1_data_o !== 8'h0F || ex_rs2_data_o !== 8'h00) begin
            errors++;
            $display("[TB] FAIL not_payload got %0d %h %h want 3 0f 00", ex_func_o, ex_rs1_data_o, ex_rs2_data_o);
        end
        nextCycle();
        drive_wb(1'b1, 3'd2, 8'hF0);
        nextCycle();
        drive_wb(1'b1, 3'd6, 8'h00);
        nextCycle();
        drive_wb(1'b0, 3'd0, 8'h00);
    endtask

    task automatic test_backpressure();
        ex_ready_i = 1'b0;
        drive_instr(1'b1, AND, 3'd1, 3'd2, 3'd7);
        nextCycle();
        drive_instr(1'b1, XOR, 3'd1, 3'd2, 3'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (instr_ready_o !== 1'b0 || ex_valid_o !== 1'b1 || ex_func_o !== AND ||
                ex_rs1_data_o !== 8'h0F || ex_rs2_data_o !== 8'hF0 || ex_rd_addr_o !== 3'd7) begin
                errors++;
                $display("[TB] FAIL backpressure got r%b v%b %0d %h %h %0d want r0 v1 0 0f f0 7",
                         instr_ready_o, ex_valid_o, ex_func_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o);
            end
            nextCycle();
        end
        ex_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release got ready %b want 1", instr_ready_o);
        end
        nextCycle();
        drive_instr(1'b0, AND, 3'd0, 3'd0, 3'd0);
        checks++;
        if (ex_func_o !== XOR || ex_rd_addr_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL bp_next got %0d rd %0d want 2 rd 0", ex_func_o, ex_rd_addr_o);
        end
    endtask

    task automatic test_set_clear_collision();
        drive_wb(1'b1, 3'd3, 8'h77);
        drive_instr(1'b1, AND, 3'd1, 3'd1, 3'd3);
        nextCycle();
        drive_wb(1'b0, 3'd0, 8'h00);
        drive_instr(1'b0, AND, 3'd0, 3'd0, 3'd0);
        checks++;
        if (pending_o[3] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collision got pending[3] %b want 1", pending_o[3]);
        end
    endtask

    task automatic test_back_to_back();
        func_t         fT [4] = '{XOR, OR, AND, NOT};
        logic [AW-1:0] aT [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
        logic [AW-1:0] bT [4] = '{3'd2, 3'd5, 3'd2, 3'd0};
        logic [AW-1:0] dT [4] = '{3'd4, 3'd5, 3'd6, 3'd1};
        for (int i = 0; i < 4; i++) begin
            drive_instr(1'b1, fT[i], aT[i], bT[i], dT[i]);
            @(negedge clk);
            checks++;
            if (instr_ready_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_%0d got ready %b want 1", i, instr_ready_o);
            end
            nextCycle();
        end
        drive_instr(1'b0, AND, 3'd0, 3'd0, 3'd0);
    endtask

    task automatic test_mid_reset();
        ex_ready_i = 1'b0;
        @(negedge clk);
        #2;
        arst_ni = 1'b0;
        #1;
        checks++;
        if (ex_valid_o !== 1'b0 || pending_o !== '0 || ex_rs1_data_o !== '0 || ex_rd_addr_o !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset got v%b pend %b rs1 %h rd %0d want v0 pend 0 rs1 00 rd 0",
                     ex_valid_o, pending_o, ex_rs1_data_o, ex_rd_addr_o);
        end
        nextCycle();
        nextCycle();
        arst_ni    = 1'b1;
        ex_ready_i = 1'b1;
        drive_instr(1'b1, AND, 3'd1, 3'd3, 3'd2);
        nextCycle();
        drive_instr(1'b0, AND, 3'd0, 3'd0, 3'd0);
        @(negedge clk);
        checks++;
        if (ex_valid_o !== 1'b1 || ex_rs1_data_o !== 8'h00 || ex_rs2_data_o !== 8'h00) begin
            errors++;
            $display("[TB] FAIL post_reset_regs got v%b %h %h want v1 00 00", ex_valid_o, ex_rs1_data_o, ex_rs2_data_o);
        end
        nextCycle();
        nextCycle();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d left want 0", expQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_issue_after_reset();
        test_raw_stall();
        test_not_operand();
        test_backpressure();
        test_set_clear_collision();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
